// File: rtl/axil_adder_pkg.sv
// Shared types and register map for the AXI4-Lite adder initiator.
// The ADDER_MASTER_TIMEOUT_EN build option is consumed by axil_adder_master.
package axil_adder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WB_A,
        S_WR_B,
        S_WB_B,
        S_RD_S,
        S_RR_S,
        S_RD_O,
        S_RR_O,
        S_DONE
    } state_e;

    localparam int unsigned ADDR_OP_A = 32'h00;
    localparam int unsigned ADDR_OP_B = 32'h04;
    localparam int unsigned ADDR_SUM  = 32'h08;
    localparam int unsigned ADDR_OVF  = 32'h0C;
    localparam int unsigned RESP_OKAY = 0;

    // States in which the master is waiting on a slave handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage

// File: rtl/axil_write_chan.sv
// AW/W dual-valid write request plus B response phase for one AXI4-Lite write.
// Shared by both operand writes; the parent selects address and data.
module axil_write_chan
    import axil_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    resp_phase,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    req_done,
    output logic                    resp_done,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [RESP_WIDTH-1:0]   bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;
    logic aw_hs, w_hs;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        awvalid   = req && !aw_done_q;
        wvalid    = req && !w_done_q;
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        req_done  = req && (aw_done_q || aw_hs) && (w_done_q || w_hs);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req && !req_done && !abort) begin
            // Each channel remembers its own acceptance so its valid drops independently.
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
        end
        awaddr    = req ? addr : '0;
        wdata     = req ? data : '0;
        bready    = resp_phase;
        resp_done = bvalid && bready;
        resp_err  = resp_done && (bresp != RESP_WIDTH'(RESP_OKAY));
    end

    assign wstrb = '1;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: rtl/axil_adder_master.sv
// AXI4-Lite initiator: writes operands A/B, then reads sum and overflow of the adder slave.
// Optional per-handshake watchdog enabled with `define ADDER_MASTER_TIMEOUT_EN.
module axil_adder_master
    import axil_adder_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int RESP_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   sum,
    output logic                    overflow,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [RESP_WIDTH-1:0]   m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [RESP_WIDTH-1:0]   m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    overflow_q, overflow_d;
    logic                    error_q, error_d;

    logic                    wc_req, wc_resp;
    logic                    wc_req_done, wc_resp_done, wc_resp_err;
    logic [ADDR_WIDTH-1:0]   wc_addr;
    logic [DATA_WIDTH-1:0]   wc_data;
    logic                    timeout;

    // Write-channel controls decode from the registered state only, keeping the handshake path loop-free.
    assign wc_req  = (state_q == S_WR_A) || (state_q == S_WR_B);
    assign wc_resp = (state_q == S_WB_A) || (state_q == S_WB_B);
    assign wc_addr = (state_q == S_WR_B) ? ADDR_WIDTH'(ADDR_OP_B) : ADDR_WIDTH'(ADDR_OP_A);
    assign wc_data = (state_q == S_WR_B) ? op_b_q : op_a_q;

    axil_write_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESP_WIDTH (RESP_WIDTH)
    ) u_write_chan (
        .clk        (m1_axi_aclk),
        .rst        (m1_axi_areset),
        .req        (wc_req),
        .resp_phase (wc_resp),
        .abort      (timeout),
        .addr       (wc_addr),
        .data       (wc_data),
        .req_done   (wc_req_done),
        .resp_done  (wc_resp_done),
        .resp_err   (wc_resp_err),
        .awaddr     (m1_axi_awaddr),
        .awvalid    (m1_axi_awvalid),
        .awready    (m1_axi_awready),
        .wdata      (m1_axi_wdata),
        .wstrb      (m1_axi_wstrb),
        .wvalid     (m1_axi_wvalid),
        .wready     (m1_axi_wready),
        .bresp      (m1_axi_bresp),
        .bvalid     (m1_axi_bvalid),
        .bready     (m1_axi_bready)
    );

    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        sum_d          = sum_q;
        overflow_d     = overflow_q;
        error_d        = error_q;
        m1_axi_arvalid = 1'b0;
        m1_axi_araddr  = '0;
        m1_axi_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    error_d = 1'b0;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: if (wc_req_done) state_d = S_WB_A;
            S_WB_A: begin
                if (wc_resp_done) begin
                    error_d = error_q | wc_resp_err;
                    state_d = S_WR_B;
                end
            end
            S_WR_B: if (wc_req_done) state_d = S_WB_B;
            S_WB_B: begin
                if (wc_resp_done) begin
                    error_d = error_q | wc_resp_err;
                    state_d = S_RD_S;
                end
            end
            S_RD_S: begin
                m1_axi_arvalid = 1'b1;
                m1_axi_araddr  = ADDR_WIDTH'(ADDR_SUM);
                if (m1_axi_arready) state_d = S_RR_S;
            end
            S_RR_S: begin
                m1_axi_rready = 1'b1;
                if (m1_axi_rvalid) begin
                    sum_d   = m1_axi_rdata;
                    error_d = error_q | (m1_axi_rresp != RESP_WIDTH'(RESP_OKAY));
                    state_d = S_RD_O;
                end
            end
            S_RD_O: begin
                m1_axi_arvalid = 1'b1;
                m1_axi_araddr  = ADDR_WIDTH'(ADDR_OVF);
                if (m1_axi_arready) state_d = S_RR_O;
            end
            S_RR_O: begin
                m1_axi_rready = 1'b1;
                if (m1_axi_rvalid) begin
                    overflow_d = m1_axi_rdata[0];
                    error_d    = error_q | (m1_axi_rresp != RESP_WIDTH'(RESP_OKAY));
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A watchdog expiry abandons whatever handshake is pending and reports it as an error.
        if (timeout) begin
            state_d = S_DONE;
            error_d = 1'b1;
        end
    end

`ifdef ADDER_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    assign timeout = is_wait_state(state_q) && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (is_wait_state(state_q)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) timer_q <= '0;
        else               timer_q <= timer_d;
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    assign busy     = is_wait_state(state_q);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule
